// File: rtl/edge_view_sequencer.sv
// edge_view_sequencer
//   Frame-synchronous controller for the edge streaming datapath. Image select,
//   display mode and preprocess enable change only at start-of-frame, driven by
//   manual next-image / next-mode requests or by an auto slideshow. After each
//   applied change, blank_o masks SETTLE_FRAMES pipeline-flush frames.
// Ports
//   clock, resetn              clock, asynchronous active-low reset
//   sof_i                      1-cycle start-of-frame pulse (apply edge)
//   next_img_i, next_mode_i    1-cycle advance requests, latched until next SOF
//   auto_en_i, pre_en_i        level controls, sampled at SOF
//   sel_im_o, mode_o, pre_en_o applied image select / mode / preprocess enable
//   blank_o                    downstream plot suppression
//   change_o                   1-cycle pulse after an applied change
//   frame_cnt_o                free-running SOF counter
module edge_view_sequencer #(
    parameter int unsigned NUM_IMG       = 5,
    parameter int unsigned DWELL_FRAMES  = 120,
    parameter int unsigned SETTLE_FRAMES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        sof_i,
    input  logic        next_img_i,
    input  logic        next_mode_i,
    input  logic        auto_en_i,
    input  logic        pre_en_i,
    output logic [2:0]  sel_im_o,
    output logic [1:0]  mode_o,
    output logic        pre_en_o,
    output logic        blank_o,
    output logic        change_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned IMG_W    = 3;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned FCNT_W   = 16;
    localparam int unsigned DWELL_W  = 16;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [IMG_W-1:0]    IMG_LAST    = IMG_W'(NUM_IMG - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_FRAMES);
    localparam bit                  SETTLE_EN   = (SETTLE_FRAMES > 0);

    typedef enum logic {S_RUN, S_SETTLE} state_t;
    localparam state_t RESET_STATE = SETTLE_EN ? S_SETTLE : S_RUN;

    state_t               state_q, state_n;
    logic [SETTLE_W-1:0]  settle_q, settle_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;
    logic                 auto_q, auto_n;
    logic                 pend_img_q, pend_img_n;
    logic                 pend_mode_q, pend_mode_n;
    logic [IMG_W-1:0]     sel_n;
    logic [MODE_W-1:0]    mode_n;
    logic                 pre_n;
    logic                 blank_n;
    logic                 change_n;
    logic [FCNT_W-1:0]    fcnt_n;
    logic                 req_img, req_mode, changed;
    logic [IMG_W-1:0]     sel_inc;

    // image select advance with wrap at NUM_IMG-1
    assign sel_inc = (sel_im_o == IMG_LAST) ? '0 : sel_im_o + IMG_W'(1);

    // next-state and output decode
    always_comb begin
        state_n     = state_q;
        settle_n    = settle_q;
        dwell_n     = dwell_q;
        auto_n      = auto_q;
        sel_n       = sel_im_o;
        mode_n      = mode_o;
        pre_n       = pre_en_o;
        fcnt_n      = frame_cnt_o;
        change_n    = 1'b0;
        changed     = 1'b0;
        // a request coincident with SOF is applied at that SOF
        req_img     = pend_img_q | next_img_i;
        req_mode    = pend_mode_q | next_mode_i;
        pend_img_n  = req_img;
        pend_mode_n = req_mode;

        if (sof_i) begin
            fcnt_n      = frame_cnt_o + FCNT_W'(1);
            auto_n      = auto_en_i;
            pre_n       = pre_en_i;
            pend_img_n  = 1'b0;
            pend_mode_n = 1'b0;

            // manual step wins over an auto tick in the same frame
            if (req_img || req_mode) begin
                if (req_img)  sel_n  = sel_inc;
                if (req_mode) mode_n = mode_o + MODE_W'(1);
                dwell_n = '0;
            end else if (auto_q) begin
                if (dwell_q == DWELL_LAST) begin
                    mode_n  = mode_o + MODE_W'(1);
                    if (mode_o == 2'b11) sel_n = sel_inc;
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell_q + DWELL_W'(1);
                end
            end

            // dwell restarts on auto enable rising and is parked while disabled
            if (!auto_q || !auto_en_i) dwell_n = '0;

            changed  = (sel_n != sel_im_o) || (mode_n != mode_o) || (pre_n != pre_en_o);
            change_n = changed;

            if (changed && SETTLE_EN) begin
                state_n  = S_SETTLE;
                settle_n = SETTLE_LOAD;
            end else if (state_q == S_SETTLE) begin
                settle_n = settle_q - SETTLE_W'(1);
                if (settle_q == SETTLE_W'(1)) state_n = S_RUN;
            end
        end

        blank_n = (state_n == S_SETTLE);
    end

    // state and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RESET_STATE;
            settle_q    <= SETTLE_LOAD;
            dwell_q     <= '0;
            auto_q      <= 1'b0;
            pend_img_q  <= 1'b0;
            pend_mode_q <= 1'b0;
            sel_im_o    <= '0;
            mode_o      <= '0;
            pre_en_o    <= 1'b0;
            blank_o     <= SETTLE_EN;
            change_o    <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            state_q     <= state_n;
            settle_q    <= settle_n;
            dwell_q     <= dwell_n;
            auto_q      <= auto_n;
            pend_img_q  <= pend_img_n;
            pend_mode_q <= pend_mode_n;
            sel_im_o    <= sel_n;
            mode_o      <= mode_n;
            pre_en_o    <= pre_n;
            blank_o     <= blank_n;
            change_o    <= change_n;
            frame_cnt_o <= fcnt_n;
        end
    end

endmodule
